sun: RTL and testbench
======================

SUN -- requirements
Module: sun

Interface
REQ-001 SHALL have these ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  reset; one clock; reset is synchronous and active-high.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  register address; full compare, no aliasing.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  transfer-complete.

REQ-002 SHALL implement this register map (unmapped reads return 0; unmapped writes ignored):
- 0x0 CTRL: RW; bit0 EN.
- 0x1 THRESH: RW; [7:0].
- 0x2 XMAX: RW; [7:0], frame width.
- 0x3 YMAX: RW; [7:0], frame height.
- 0x4 PIXEL: WO; [7:0] pixel value; reads return 0.
- 0x5 STATUS: RO; bit0 EN, bit1 BUSY, bit2 DONE, bit3 FOUND, [15:8] pixels received.
- 0x6 BRIGHT: RO; [7:0] count of bright pixels.
- 0x8 H: RO; [7:0] sun centre x.
- 0x9 K: RO; [7:0] sun centre y.
- Unused upper bits SHALL read 0.

Function
REQ-003 APB transfer: setup phase is psel=1, penable=0; access phase is psel=1, penable=1; the transfer completes on the rising edge where access phase and pready=1.
REQ-004 pready SHALL be combinational: 1 in access phase, except 0 while a PIXEL write is issued in PROC state; it SHALL be 0 outside access phase.
REQ-005 prdata SHALL be combinational: the addressed register value during a read access phase, else 0.
REQ-006 Register writes SHALL take effect on the completing edge; only pwdata[7:0] (CTRL: bit0) is stored.
REQ-007 FSM states: IDLE, WAIT, PROC, DONE.
- IDLE to WAIT when EN is written 1.
- Any state to IDLE when EN is written 0; frame progress clears; H, K, BRIGHT, FOUND are kept.
REQ-008 Raster order: x counts 0..XMAX-1, then x wraps to 0 and y increments, up to YMAX-1. An XMAX or YMAX of 0 SHALL be treated as 1.
REQ-009 Accepted PIXEL write in WAIT or DONE:
- Latch the value and enter PROC for exactly 2 cycles.
- From DONE: first clear DONE, FOUND, BRIGHT, the pixel count and the bounding box.
REQ-010 PROC processing:
- A pixel is bright when its value is strictly greater than THRESH.
- A bright pixel increments BRIGHT and updates the bounding box (min_x, max_x, min_y, max_y).
- Advance x/y and the pixel count.
REQ-011 After PROC:
- If pixel count = XMAX*YMAX: go to DONE, set DONE.
- Else return to WAIT.
REQ-012 On entering DONE:
- FOUND = (BRIGHT != 0).
- H = (min_x+max_x)>>1; K = (min_y+max_y)>>1.
- If no bright pixel: H = K = 0xFF.
REQ-013 BUSY SHALL be 1 in WAIT with pixel count > 0, and in PROC.
REQ-014 PIXEL writes in IDLE SHALL complete (pready=1) and be ignored.
REQ-015 Writing XMAX, YMAX or THRESH while BUSY SHALL restart the frame: counters and bounding box clear, state goes to WAIT.
REQ-016 Arithmetic SHALL be unsigned; the bounding-box sum SHALL be 9 bits wide before the shift.

Reset
REQ-017 While preset=1 at a clock edge:
- All registers SHALL clear to 0, except H and K, which are set to 0xFF.
- The FSM goes to IDLE.
REQ-018 During reset, pready and prdata SHALL follow REQ-004/005 from the reset register values; reset mid-frame discards the frame.

Verification
REQ-019 Write CTRL=1, then read STATUS -> 0x00000001.
REQ-020 Write THRESH=0x0F, read THRESH -> 0x0000000F; read 0x7 -> 0.
REQ-021 XMAX=2, YMAX=2, four PIXEL writes of 0x10, gap of 10 cycles each:
- STATUS -> 0x0000040D.
- BRIGHT -> 4.
- H -> 0, K -> 0.
REQ-022 Same 2x2 frame with pixels 0x05, 0x0F, 0x05, 0x20:
- FOUND=1, BRIGHT=1.
- H=1, K=1.
- Pixel 0x0F is not bright (equal to threshold).
REQ-023 PIXEL write issued immediately after another -> pready low for the remaining PROC cycles, then completes; all pixels are counted.
REQ-024 Write CTRL=0 mid-frame -> STATUS=0x00000000; a subsequent PIXEL write is ignored; preset mid-frame -> H=K=0xFF, STATUS=0.

Source files
------------

// File: rtl/sun.sv
// APB-attached sun locator: accumulates one frame of pixels in raster order,
// counts pixels above threshold and reports the bright region's bounding-box centre.
module sun (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_PROC = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  r_state;
  logic        r_phase;
  logic        r_en;
  logic [7:0]  r_thresh;
  logic [7:0]  r_xmax;
  logic [7:0]  r_ymax;
  logic [7:0]  r_pixel;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [15:0] r_count;
  logic [7:0]  r_bright;
  logic        r_done;
  logic        r_found;
  logic [7:0]  r_min_x;
  logic [7:0]  r_max_x;
  logic [7:0]  r_min_y;
  logic [7:0]  r_max_y;
  logic [7:0]  r_h;
  logic [7:0]  r_k;

  logic        w_access;
  logic        w_wr;
  logic        w_busy;
  logic        w_bright;
  logic [7:0]  w_xm;
  logic [7:0]  w_ym;
  logic [15:0] w_total;
  logic [8:0]  w_hsum;
  logic [8:0]  w_ksum;
  logic        w_unused;

  assign w_access = psel & penable;
  // A PIXEL write is held off until the current pixel has been processed.
  assign pready   = w_access & ~(pwrite && (paddr == 32'h4) && (r_state == ST_PROC));
  assign w_wr     = w_access & pwrite & pready;
  assign w_busy   = ((r_state == ST_WAIT) && (r_count != 16'd0)) || (r_state == ST_PROC);
  assign w_bright = r_pixel > r_thresh;
  assign w_xm     = (r_xmax == 8'd0) ? 8'd1 : r_xmax;
  assign w_ym     = (r_ymax == 8'd0) ? 8'd1 : r_ymax;
  assign w_total  = {8'd0, w_xm} * {8'd0, w_ym};
  assign w_hsum   = {1'b0, r_min_x} + {1'b0, r_max_x};
  assign w_ksum   = {1'b0, r_min_y} + {1'b0, r_max_y};
  assign w_unused = ^pwdata[31:8];

  always_comb begin
    prdata = 32'd0;
    if (w_access && !pwrite) begin
      case (paddr)
        32'h0: prdata = {31'd0, r_en};
        32'h1: prdata = {24'd0, r_thresh};
        32'h2: prdata = {24'd0, r_xmax};
        32'h3: prdata = {24'd0, r_ymax};
        32'h5: prdata = {16'd0, r_count[7:0], 4'd0, r_found, r_done, w_busy, r_en};
        32'h6: prdata = {24'd0, r_bright};
        32'h8: prdata = {24'd0, r_h};
        32'h9: prdata = {24'd0, r_k};
        default: prdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= ST_IDLE;
      r_phase  <= 1'b0;
      r_en     <= 1'b0;
      r_thresh <= 8'd0;
      r_xmax   <= 8'd0;
      r_ymax   <= 8'd0;
      r_pixel  <= 8'd0;
      r_x      <= 8'd0;
      r_y      <= 8'd0;
      r_count  <= 16'd0;
      r_bright <= 8'd0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_min_x  <= 8'd0;
      r_max_x  <= 8'd0;
      r_min_y  <= 8'd0;
      r_max_y  <= 8'd0;
      r_h      <= 8'hFF;
      r_k      <= 8'hFF;
    end else begin
      if (r_state == ST_PROC) begin
        if (!r_phase) begin
          r_phase <= 1'b1;
          if (w_bright) begin
            r_bright <= r_bright + 8'd1;
            // First bright pixel of the frame seeds the box.
            if (r_bright == 8'd0 || r_x < r_min_x) r_min_x <= r_x;
            if (r_bright == 8'd0 || r_x > r_max_x) r_max_x <= r_x;
            if (r_bright == 8'd0 || r_y < r_min_y) r_min_y <= r_y;
            if (r_bright == 8'd0 || r_y > r_max_y) r_max_y <= r_y;
          end
          r_count <= r_count + 16'd1;
          if (r_x >= w_xm - 8'd1) begin
            r_x <= 8'd0;
            r_y <= (r_y >= w_ym - 8'd1) ? 8'd0 : r_y + 8'd1;
          end else begin
            r_x <= r_x + 8'd1;
          end
        end else begin
          r_phase <= 1'b0;
          if (r_count == w_total) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_found <= (r_bright != 8'd0);
            r_h     <= (r_bright != 8'd0) ? w_hsum[8:1] : 8'hFF;
            r_k     <= (r_bright != 8'd0) ? w_ksum[8:1] : 8'hFF;
          end else begin
            r_state <= ST_WAIT;
          end
        end
      end

      // Bus writes are applied last so they override same-cycle processing.
      if (w_wr) begin
        case (paddr)
          32'h0: begin
            r_en <= pwdata[0];
            if (!pwdata[0]) begin
              r_state <= ST_IDLE;
              r_phase <= 1'b0;
              r_x     <= 8'd0;
              r_y     <= 8'd0;
              r_count <= 16'd0;
              r_done  <= 1'b0;
            end else if (r_state == ST_IDLE) begin
              r_state  <= ST_WAIT;
              r_bright <= 8'd0;
              r_found  <= 1'b0;
            end
          end
          32'h1, 32'h2, 32'h3: begin
            if (paddr == 32'h1) r_thresh <= pwdata[7:0];
            if (paddr == 32'h2) r_xmax <= pwdata[7:0];
            if (paddr == 32'h3) r_ymax <= pwdata[7:0];
            if (w_busy) begin
              r_state  <= ST_WAIT;
              r_phase  <= 1'b0;
              r_x      <= 8'd0;
              r_y      <= 8'd0;
              r_count  <= 16'd0;
              r_bright <= 8'd0;
              r_min_x  <= 8'd0;
              r_max_x  <= 8'd0;
              r_min_y  <= 8'd0;
              r_max_y  <= 8'd0;
            end
          end
          32'h4: begin
            if (r_state == ST_WAIT || r_state == ST_DONE) begin
              r_pixel <= pwdata[7:0];
              r_state <= ST_PROC;
              r_phase <= 1'b0;
              if (r_state == ST_DONE) begin
                r_done   <= 1'b0;
                r_found  <= 1'b0;
                r_bright <= 8'd0;
                r_count  <= 16'd0;
                r_x      <= 8'd0;
                r_y      <= 8'd0;
                r_min_x  <= 8'd0;
                r_max_x  <= 8'd0;
                r_min_y  <= 8'd0;
                r_max_y  <= 8'd0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sun.sv
// Bench for sun: directed register/frame scenarios plus random APB traffic
// compared against a frame-level model (pixel list, bright count, bounding box).
module tb_sun;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  always #5 pclk = ~pclk;

  sun dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Frame-level model
  logic       m_en, m_done, m_found;
  logic [7:0] m_thresh, m_xmax, m_ymax, m_bright, m_h, m_k;
  int         m_q[$];

  function automatic int dim(input logic [7:0] v);
    return (v == 8'd0) ? 1 : int'(v);
  endfunction

  function automatic logic m_busy();
    return m_en && !m_done && (m_q.size() > 0);
  endfunction

  task automatic m_reset();
    m_en = 0; m_done = 0; m_found = 0;
    m_thresh = 0; m_xmax = 0; m_ymax = 0; m_bright = 0;
    m_h = 8'hFF; m_k = 8'hFF;
    m_q.delete();
  endtask

  task automatic m_eval();
    int nb, mnx, mxx, mny, mxy, xm;
    xm = dim(m_xmax);
    nb = 0; mnx = 999; mxx = -1; mny = 999; mxy = -1;
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i] > int'(m_thresh)) begin
        nb++;
        if (i % xm < mnx) mnx = i % xm;
        if (i % xm > mxx) mxx = i % xm;
        if (i / xm < mny) mny = i / xm;
        if (i / xm > mxy) mxy = i / xm;
      end
    end
    m_bright = 8'(nb);
    if (m_q.size() == xm * dim(m_ymax)) begin
      m_done  = 1;
      m_found = (nb != 0);
      m_h     = (nb != 0) ? 8'((mnx + mxx) / 2) : 8'hFF;
      m_k     = (nb != 0) ? 8'((mny + mxy) / 2) : 8'hFF;
    end
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    case (a)
      32'h0: begin
        if (d[0] && !m_en) begin
          m_en = 1; m_bright = 0; m_found = 0;
        end else if (!d[0]) begin
          m_en = 0; m_done = 0; m_q.delete();
        end
      end
      32'h1, 32'h2, 32'h3: begin
        if (m_busy()) begin
          m_q.delete(); m_bright = 0;
        end
        if (a == 32'h1) m_thresh = d[7:0];
        if (a == 32'h2) m_xmax = d[7:0];
        if (a == 32'h3) m_ymax = d[7:0];
      end
      32'h4: begin
        if (m_en) begin
          if (m_done) begin
            m_done = 0; m_found = 0; m_bright = 0; m_q.delete();
          end
          m_q.push_back(int'(d[7:0]));
          m_eval();
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      32'h0: r[0] = m_en;
      32'h1: r[7:0] = m_thresh;
      32'h2: r[7:0] = m_xmax;
      32'h3: r[7:0] = m_ymax;
      32'h5: begin
        r[0] = m_en; r[1] = m_busy(); r[2] = m_done; r[3] = m_found;
        r[15:8] = 8'(m_q.size());
      end
      32'h6: r[7:0] = m_bright;
      32'h8: r[7:0] = m_h;
      32'h9: r[7:0] = m_k;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Bus helpers: entered and left #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int stall);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1; stall = 0;
    @(negedge pclk);
    while (!pready && stall < 20) begin
      stall++;
      @(negedge pclk);
    end
    if (stall >= 20) check("pready_timeout", {31'd0, pready}, 32'd1);
    rd = prdata;
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int st;
    bus(1'b1, a, d, rd, st);
    m_write(a, d);
    if (a == 32'h4) idle(2);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    int st;
    bus(1'b0, a, 32'd0, v, st);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, m_read(a));
  endtask

  task automatic do_reset();
    preset = 1;
    idle(2);
    preset = 0;
    m_reset();
  endtask

  initial begin
    logic [31:0] v, dummy;
    int st0, st1;
    int sel;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; preset = 0;
    @(posedge pclk); #1;
    do_reset();

    rd(32'h5, v); check("rst_status", v, 32'h0);
    rd(32'h8, v); check("rst_h", v, 32'hFF);
    rd(32'h9, v); check("rst_k", v, 32'hFF);

    wr(32'h0, 32'h1);
    rd(32'h5, v); check("en_status", v, 32'h1);
    wr(32'h1, 32'hFFFF_FF0F);
    rd(32'h1, v); check("thresh", v, 32'hF);
    rd(32'h7, v); check("unmapped_rd", v, 32'h0);
    rd(32'h4, v); check("pixel_rd", v, 32'h0);

    wr(32'h2, 32'h2); wr(32'h3, 32'h2);
    for (int i = 0; i < 4; i++) begin
      wr(32'h4, 32'h10);
      idle(10);
    end
    rd(32'h5, v); check("f1_status", v, 32'h40D);
    rd(32'h6, v); check("f1_bright", v, 32'h4);
    rd(32'h8, v); check("f1_h", v, 32'h0);
    rd(32'h9, v); check("f1_k", v, 32'h0);

    wr(32'h4, 32'h05); wr(32'h4, 32'h0F); wr(32'h4, 32'h05); wr(32'h4, 32'h20);
    rd(32'h5, v); check("f2_status", v, 32'h40D);
    rd(32'h6, v); check("f2_bright", v, 32'h1);
    rd(32'h8, v); check("f2_h", v, 32'h1);
    rd(32'h9, v); check("f2_k", v, 32'h1);

    // Back-to-back pixel writes: second one stalls for the remaining PROC cycle.
    for (int p = 0; p < 2; p++) begin
      bus(1'b1, 32'h4, 32'h30, dummy, st0);
      bus(1'b1, 32'h4, 32'h31, dummy, st1);
      m_write(32'h4, 32'h30);
      m_write(32'h4, 32'h31);
      idle(2);
      check("b2b_stall", st1, 32'd1);
      rd_chk("b2b_status", 32'h5);
    end
    rd(32'h5, v); check("b2b_final", v, 32'h40D);

    wr(32'h4, 32'h40);
    rd(32'h5, v); check("mid_status", v, 32'h103);
    wr(32'h0, 32'h0);
    rd(32'h5, v); check("dis_status", v, 32'h0);
    bus(1'b1, 32'h4, 32'h40, dummy, st0);
    m_write(32'h4, 32'h40);
    idle(2);
    check("idle_pix_stall", st0, 32'd0);
    rd(32'h5, v); check("idle_pix_status", v, 32'h0);
    wr(32'h0, 32'h1);
    wr(32'h4, 32'h40);
    do_reset();
    rd(32'h8, v); check("rst2_h", v, 32'hFF);
    rd(32'h9, v); check("rst2_k", v, 32'hFF);
    rd(32'h5, v); check("rst2_status", v, 32'h0);

    wr(32'h0, 32'h1);
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 55) begin
        wr(32'h4, 32'($urandom_range(0, 255)));
      end else if (sel < 80) begin
        rd_chk("rnd_rd", 32'($urandom_range(0, 10)));
      end else if (sel < 84) begin
        wr(32'h1, 32'($urandom_range(0, 255)));
      end else if (sel < 90) begin
        wr(32'($urandom_range(2, 3)), 32'($urandom_range(0, 3)));
      end else if (sel < 95) begin
        wr(32'h0, ($urandom_range(0, 9) < 6) ? 32'h1 : 32'h0);
      end else begin
        wr(32'h0001_0004 + 32'($urandom_range(0, 1)), 32'($urandom_range(0, 255)));
      end
    end
    for (int a = 0; a < 10; a++) rd_chk("end_rd", 32'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
